rv32i_debug_ctrl: RTL and testbench
===================================

# rv32i_debug_ctrl

APB-slave debug controller for the RV32I core. Decodes the debug register map, owns the run/halt/step sequencing of the core's FSM and two hardware PC breakpoints, and records halt causes. It also gives the debugger GPR and PC access while the core is halted. It sits between the external APB debug bus and the core's debug port.

## Interface
- Parameters: none (XLEN=32 and all addresses and halt_cause_e come from rv32i_pkg).
- Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  12  APB byte address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  tied 1 (zero wait states)
- pslverr  out  1  error response, valid in access phase
- core_halted  in  1  core FSM is in CPU_HALTED
- core_pc  in  32  current PC
- core_instr  in  32  current instruction
- core_fetch_valid  in  1  fetch of core_pc this cycle
- core_ebreak  in  1  EBREAK retiring this cycle
- dbg_halt_req  out  1  level halt request
- dbg_resume_req  out  1  one-cycle resume pulse
- dbg_step_req  out  1  one-cycle single-step pulse
- dbg_bp_hit  out  1  combinational breakpoint match; core must not execute the fetched instruction
- dbg_reg_addr  out  5  GPR index
- dbg_reg_we  out  1  GPR write strobe
- dbg_reg_wdata  out  32  GPR write data
- dbg_reg_rdata  in  32  GPR read data, combinational from dbg_reg_addr
- dbg_pc_we  out  1  PC overwrite strobe
- dbg_pc_wdata  out  32  new PC

## Operation
- Transfers:
  - An access is `psel & penable`. A setup is `psel & ~penable`.
  - Reads: prdata is registered on the setup cycle and held through the access cycle.
  - Writes: take effect at the access-cycle clock edge.
- Register map:
  - CTRL 0x000 (W1P): bit0 = halt, bit1 = resume, bit2 = step. Reads return 0.
  - STATUS 0x004 (RO): bit0 = halted (state HALTED), bit1 = running (state RUN), [7:4] = halt cause.
  - PC 0x008: RW. Writes are accepted only in HALTED and pulse dbg_pc_we.
  - INSTR 0x00C: RO.
  - GPR 0x010–0x08C: dbg_reg_addr = paddr[6:2] − 4. Reads are always allowed. Writes are accepted only in HALTED. A write to x0 returns OK with no strobe.
  - BPn_ADDR 0x100 / 0x108: RW. Bits [1:0] read as 0.
  - BPn_CTRL 0x104 / 0x10C: bit0 = enable.
- pslverr = 1 for: unmapped address, a write to STATUS/INSTR, or a PC/GPR write while not HALTED. An erroring access changes no state.
- Breakpoint match: dbg_bp_hit = (state == RUN) & core_fetch_valid & OR over n of (BPn_en & BPn_addr[31:2] == core_pc[31:2]).
- FSM states: RUN, HALT_WAIT, HALTED, RESUME_WAIT, STEP_FALL, STEP_RISE.
  - RUN → HALT_WAIT on a CTRL halt write, dbg_bp_hit, or core_ebreak. The cause is latched at that edge with priority EBREAK > BREAKPOINT > REQUEST.
  - HALT_WAIT → HALTED when core_halted = 1.
  - HALTED, on a step write → STEP_FALL, pulsing dbg_step_req.
  - HALTED, on a resume write (no step) → RESUME_WAIT, pulsing dbg_resume_req.
  - STEP_FALL → STEP_RISE when core_halted = 0.
  - STEP_RISE → HALTED when core_halted = 1, with cause = HALT_STEP.
  - RESUME_WAIT → RUN when core_halted = 0, with cause = HALT_NONE.
- dbg_halt_req = 1 in HALT_WAIT, HALTED and STEP_RISE.
- Ignored without error: a halt write in any state other than RUN; resume/step writes outside HALTED; dbg_bp_hit and core_ebreak outside RUN.
- Reset (rst_n low, asynchronous): state = RUN, cause = HALT_NONE, all BP registers 0, every output 0 except pready = 1. Reset mid-step or mid-halt returns to RUN immediately.

## Timing
- Halt latency: a CTRL halt access, breakpoint hit or EBREAK at cycle N gives dbg_halt_req = 1 from N+1.
- dbg_bp_hit is combinational (zero latency).
- dbg_resume_req and dbg_step_req are high for exactly the cycle after the accepting access.
- dbg_reg_we and dbg_pc_we are combinational in the accepting access cycle, with data equal to pwdata.
- STATUS reads reflect state as of the setup-cycle edge.
- core_halted is level-sampled each cycle. No timeout.

## Test plan
- CTRL write 0x1 in RUN, core raises core_halted 3 cycles later → dbg_halt_req = 1 from the next cycle; STATUS reads 0x11 (halted, cause REQUEST).
- BP0_ADDR = 0x0000_0040, BP0_CTRL = 1; fetch pc 0x40 with core_fetch_valid → dbg_bp_hit = 1 in the same cycle; after core_halted, STATUS = 0x21.
- While halted, CTRL = 0x4 → one-cycle dbg_step_req; core_halted goes 1→0→1 → HALTED, STATUS = 0x31. Then CTRL = 0x2 → dbg_resume_req pulse; after core_halted falls, STATUS = 0x02.
- GPR write to x5 (0x024) of 0xDEAD_BEEF:
  - In RUN → pslverr = 1, dbg_reg_we = 0.
  - In HALTED → dbg_reg_addr = 5, dbg_reg_we pulse, pslverr = 0.
  - Write to x0 (0x010) → no strobe, pslverr = 0.
- Same-cycle core_ebreak and BP hit in RUN → cause = EBREAK (STATUS[7:4] = 4). CTRL = 0x6 while halted → step only.
- Assert rst_n low in STEP_FALL → all outputs cleared asynchronously and STATUS = 0x02 after release. Read of 0x200 → pslverr = 1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, debug
// register map and halt-cause encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] DBG_CTRL     = 12'h000;
  localparam logic [11:0] DBG_STATUS   = 12'h004;
  localparam logic [11:0] DBG_PC       = 12'h008;
  localparam logic [11:0] DBG_INSTR    = 12'h00C;
  localparam logic [11:0] DBG_GPR_LO   = 12'h010;
  localparam logic [11:0] DBG_GPR_HI   = 12'h08C;
  localparam logic [11:0] DBG_BP0_ADDR = 12'h100;
  localparam logic [11:0] DBG_BP0_CTRL = 12'h104;
  localparam logic [11:0] DBG_BP1_ADDR = 12'h108;
  localparam logic [11:0] DBG_BP1_CTRL = 12'h10C;

  typedef enum logic [3:0] {
    HALT_NONE       = 4'd0,
    HALT_REQUEST    = 4'd1,
    HALT_BREAKPOINT = 4'd2,
    HALT_STEP       = 4'd3,
    HALT_EBREAK     = 4'd4
  } halt_cause_e;

endpackage

// File: rtl/rv32i_debug_ctrl.sv
// APB debug controller: register map, run/halt/step FSM, 2 PC breakpoints.
// Ports: APB slave (psel..pslverr), core status in, core debug port out.
module rv32i_debug_ctrl
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [11:0]     paddr,
  input  logic [XLEN-1:0] pwdata,
  output logic [XLEN-1:0] prdata,
  output logic            pready,
  output logic            pslverr,
  input  logic            core_halted,
  input  logic [XLEN-1:0] core_pc,
  input  logic [XLEN-1:0] core_instr,
  input  logic            core_fetch_valid,
  input  logic            core_ebreak,
  output logic            dbg_halt_req,
  output logic            dbg_resume_req,
  output logic            dbg_step_req,
  output logic            dbg_bp_hit,
  output logic [4:0]      dbg_reg_addr,
  output logic            dbg_reg_we,
  output logic [XLEN-1:0] dbg_reg_wdata,
  input  logic [XLEN-1:0] dbg_reg_rdata,
  output logic            dbg_pc_we,
  output logic [XLEN-1:0] dbg_pc_wdata
);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT_WAIT,
    S_HALTED,
    S_RESUME_WAIT,
    S_STEP_FALL,
    S_STEP_RISE
  } state_e;

  state_e      state, state_nxt;
  halt_cause_e cause, cause_nxt;
  logic        step_q, step_nxt;
  logic        resume_q, resume_nxt;

  logic [29:0] bp0_addr, bp1_addr;
  logic        bp0_en, bp1_en;

  logic setup, access;
  logic sel_ctrl, sel_status, sel_pc, sel_instr;
  logic sel_gpr, sel_bp0a, sel_bp0c;
  logic sel_bp1a, sel_bp1c, mapped;
  logic run_st, halted_st;
  logic err_wr, ok_wr;
  logic halt_w, resume_w, step_w;
  logic bp_match;
  logic [4:0]      gpr_idx;
  logic [XLEN-1:0] rdata_nxt;

  assign setup  = psel & ~penable;
  assign access = psel & penable;

  assign sel_ctrl   = paddr == DBG_CTRL;
  assign sel_status = paddr == DBG_STATUS;
  assign sel_pc     = paddr == DBG_PC;
  assign sel_instr  = paddr == DBG_INSTR;
  assign sel_bp0a   = paddr == DBG_BP0_ADDR;
  assign sel_bp0c   = paddr == DBG_BP0_CTRL;
  assign sel_bp1a   = paddr == DBG_BP1_ADDR;
  assign sel_bp1c   = paddr == DBG_BP1_CTRL;
  assign sel_gpr    = (paddr >= DBG_GPR_LO) &&
                      (paddr <= DBG_GPR_HI) &&
                      (paddr[1:0] == 2'b00);

  assign mapped = sel_ctrl | sel_status | sel_pc |
                  sel_instr | sel_gpr | sel_bp0a |
                  sel_bp0c | sel_bp1a | sel_bp1c;

  assign run_st    = state == S_RUN;
  assign halted_st = state == S_HALTED;

  // Core state may only be touched while parked.
  assign err_wr = pwrite &
                  (sel_status | sel_instr |
                   ((sel_pc | sel_gpr) & ~halted_st));

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped | err_wr);
  assign ok_wr   = access & pwrite & mapped & ~err_wr;

  assign halt_w   = ok_wr & sel_ctrl & pwdata[0];
  assign resume_w = ok_wr & sel_ctrl & pwdata[1];
  assign step_w   = ok_wr & sel_ctrl & pwdata[2];

  // x1 sits at 0x014, so word index minus 4.
  assign gpr_idx = paddr[6:2] - 5'd4;

  assign dbg_reg_addr  = (psel & sel_gpr) ? gpr_idx : '0;
  assign dbg_reg_we    = ok_wr & sel_gpr & (gpr_idx != 5'd0);
  assign dbg_reg_wdata = dbg_reg_we ? pwdata : '0;
  assign dbg_pc_we     = ok_wr & sel_pc;
  assign dbg_pc_wdata  = dbg_pc_we ? pwdata : '0;

  assign bp_match = core_fetch_valid &
                    ((bp0_en & (bp0_addr == core_pc[31:2])) |
                     (bp1_en & (bp1_addr == core_pc[31:2])));
  assign dbg_bp_hit = run_st & bp_match;

  assign dbg_halt_req   = (state == S_HALT_WAIT) |
                          (state == S_HALTED) |
                          (state == S_STEP_RISE);
  assign dbg_resume_req = resume_q;
  assign dbg_step_req   = step_q;

  always_comb begin
    rdata_nxt = '0;
    unique case (1'b1)
      sel_status: rdata_nxt = {24'b0, cause, 2'b0,
                               run_st, halted_st};
      sel_pc:     rdata_nxt = core_pc;
      sel_instr:  rdata_nxt = core_instr;
      sel_gpr:    rdata_nxt = dbg_reg_rdata;
      sel_bp0a:   rdata_nxt = {bp0_addr, 2'b00};
      sel_bp0c:   rdata_nxt = {31'b0, bp0_en};
      sel_bp1a:   rdata_nxt = {bp1_addr, 2'b00};
      sel_bp1c:   rdata_nxt = {31'b0, bp1_en};
      default:    rdata_nxt = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    step_nxt   = 1'b0;
    resume_nxt = 1'b0;
    unique case (state)
      S_RUN: begin
        if (core_ebreak | dbg_bp_hit | halt_w) begin
          state_nxt = S_HALT_WAIT;
          if (core_ebreak)     cause_nxt = HALT_EBREAK;
          else if (dbg_bp_hit) cause_nxt = HALT_BREAKPOINT;
          else                 cause_nxt = HALT_REQUEST;
        end
      end
      S_HALT_WAIT: begin
        if (core_halted) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        // Step wins when both bits are written.
        if (step_w) begin
          state_nxt = S_STEP_FALL;
          step_nxt  = 1'b1;
        end else if (resume_w) begin
          state_nxt  = S_RESUME_WAIT;
          resume_nxt = 1'b1;
        end
      end
      S_STEP_FALL: begin
        if (!core_halted) state_nxt = S_STEP_RISE;
      end
      S_STEP_RISE: begin
        if (core_halted) begin
          state_nxt = S_HALTED;
          cause_nxt = HALT_STEP;
        end
      end
      S_RESUME_WAIT: begin
        if (!core_halted) begin
          state_nxt = S_RUN;
          cause_nxt = HALT_NONE;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      cause    <= HALT_NONE;
      step_q   <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cause    <= cause_nxt;
      step_q   <= step_nxt;
      resume_q <= resume_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata   <= '0;
      bp0_addr <= '0;
      bp1_addr <= '0;
      bp0_en   <= 1'b0;
      bp1_en   <= 1'b0;
    end else begin
      if (setup & ~pwrite) prdata <= rdata_nxt;
      if (ok_wr & sel_bp0a) bp0_addr <= pwdata[31:2];
      if (ok_wr & sel_bp1a) bp1_addr <= pwdata[31:2];
      if (ok_wr & sel_bp0c) bp0_en   <= pwdata[0];
      if (ok_wr & sel_bp1c) bp1_en   <= pwdata[0];
    end
  end

endmodule

// File: tb/tb_rv32i_debug_ctrl.sv
// Self-checking bench for rv32i_debug_ctrl.
// Random APB/core stimulus against a small behavioural model.
module tb_rv32i_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        core_halted;
  logic [31:0] core_pc, core_instr;
  logic        core_fetch_valid, core_ebreak;
  logic        dbg_halt_req, dbg_resume_req, dbg_step_req;
  logic        dbg_bp_hit;
  logic [4:0]  dbg_reg_addr;
  logic        dbg_reg_we;
  logic [31:0] dbg_reg_wdata, dbg_reg_rdata;
  logic        dbg_pc_we;
  logic [31:0] dbg_pc_wdata;

  int total = 0;
  int bad   = 0;

  // Model: debugger-visible view of the controller.
  logic        m_run, m_halted;
  logic [3:0]  m_cause;
  logic [31:0] m_bp_addr [2];
  logic        m_bp_en   [2];

  // Core register file stand-in: value identifies the index.
  assign dbg_reg_rdata = 32'hA5A5_0000 | {27'b0, dbg_reg_addr};

  always #5 clk = ~clk;

  rv32i_debug_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .core_halted(core_halted), .core_pc(core_pc),
    .core_instr(core_instr),
    .core_fetch_valid(core_fetch_valid),
    .core_ebreak(core_ebreak),
    .dbg_halt_req(dbg_halt_req),
    .dbg_resume_req(dbg_resume_req),
    .dbg_step_req(dbg_step_req),
    .dbg_bp_hit(dbg_bp_hit),
    .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_we(dbg_reg_we),
    .dbg_reg_wdata(dbg_reg_wdata),
    .dbg_reg_rdata(dbg_reg_rdata),
    .dbg_pc_we(dbg_pc_we),
    .dbg_pc_wdata(dbg_pc_wdata)
  );

  function automatic logic [31:0] m_status();
    return {24'b0, m_cause, 2'b0, m_run, m_halted};
  endfunction

  function automatic logic m_hit(logic [31:0] pc, logic fv);
    logic h;
    h = 1'b0;
    for (int n = 0; n < 2; n++)
      if (m_bp_en[n] && (m_bp_addr[n] >> 2) == (pc >> 2))
        h = 1'b1;
    return m_run && fv && h;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(
    input  logic [11:0] a,
    input  logic [31:0] d,
    output logic        err,
    output logic        rwe,
    output logic [4:0]  ra,
    output logic        pwe,
    output logic [31:0] wd
  );
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1;
    paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    #2;
    err = pslverr;
    rwe = dbg_reg_we;
    ra  = dbg_reg_addr;
    pwe = dbg_pc_we;
    wd  = rwe ? dbg_reg_wdata : dbg_pc_wdata;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(
    input  logic [11:0] a,
    output logic [31:0] d,
    output logic        err
  );
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    #2;
    d   = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    #12;
    total++;
    if ({dbg_halt_req, dbg_resume_req, dbg_step_req,
         dbg_bp_hit, dbg_reg_we, dbg_pc_we, pslverr}
        !== 7'b0 || prdata !== 32'h0 || pready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outs: prdata=%h pready=%b hr=%b",
               prdata, pready, dbg_halt_req);
    end
    @(negedge clk) rst_n = 1;
    cyc(2);
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status() || e !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got %h/%b want %h/0",
               d, e, m_status());
    end
  endtask

  task automatic test_halt_request();
    logic [31:0] d, wd, pc, ins;
    logic e, rwe, pwe;
    logic [4:0] ra;
    apb_write(12'h000, 32'h1, e, rwe, ra, pwe, wd);
    total++;
    if (dbg_halt_req !== 1'b1 || e !== 1'b0) begin
      bad++;
      $display("FAIL halt_latency: got %b/%b want 1/0",
               dbg_halt_req, e);
    end
    m_run = 0;
    cyc(2);
    core_halted = 1;
    cyc(2);
    m_halted = 1;
    m_cause  = 4'd1;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL halt_status: got %h want %h",
               d, m_status());
    end
    pc  = $urandom;
    ins = $urandom;
    core_pc = pc;
    core_instr = ins;
    apb_read(12'h008, d, e);
    total++;
    if (d !== pc || e !== 1'b0) begin
      bad++;
      $display("FAIL pc_read: got %h want %h", d, pc);
    end
    apb_read(12'h00C, d, e);
    total++;
    if (d !== ins || e !== 1'b0) begin
      bad++;
      $display("FAIL instr_read: got %h want %h", d, ins);
    end
    // A second halt while halted is silently ignored.
    apb_write(12'h000, 32'h1, e, rwe, ra, pwe, wd);
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL rehalt_status: got %h want %h",
               d, m_status());
    end
  endtask

  task automatic test_gpr_halted();
    logic [31:0] d, wd, v;
    logic e, rwe, pwe;
    logic [4:0] ra;
    int idx;
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(1, 31);
      v   = $urandom;
      apb_write(12'(16 + 4 * idx), v, e, rwe, ra, pwe, wd);
      total++;
      if (e !== 0 || rwe !== 1 || ra !== 5'(idx) ||
          wd !== v || pwe !== 0) begin
        bad++;
        $display("FAIL gpr_wr: err=%b we=%b a=%0d d=%h want a=%0d d=%h",
                 e, rwe, ra, wd, idx, v);
      end
      idx = $urandom_range(0, 31);
      apb_read(12'(16 + 4 * idx), d, e);
      total++;
      if (d !== (32'hA5A5_0000 | 32'(idx)) || e !== 0) begin
        bad++;
        $display("FAIL gpr_rd: x%0d got %h", idx, d);
      end
    end
    apb_write(12'h010, 32'hDEAD_BEEF, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 0 || rwe !== 0) begin
      bad++;
      $display("FAIL gpr_x0: err=%b we=%b want 0/0", e, rwe);
    end
    apb_write(12'h024, 32'hDEAD_BEEF, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 0 || rwe !== 1 || ra !== 5'd5 ||
        wd !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL gpr_x5: err=%b we=%b a=%0d d=%h",
               e, rwe, ra, wd);
    end
    v = $urandom;
    apb_write(12'h008, v, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 0 || pwe !== 1 || wd !== v) begin
      bad++;
      $display("FAIL pc_wr: err=%b we=%b d=%h want %h",
               e, pwe, wd, v);
    end
    apb_write(12'h004, 32'h0, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 1) begin
      bad++;
      $display("FAIL status_wr_err: got %b want 1", e);
    end
    apb_write(12'h00C, 32'h0, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 1) begin
      bad++;
      $display("FAIL instr_wr_err: got %b want 1", e);
    end
    apb_read(12'h200, d, e);
    total++;
    if (e !== 1) begin
      bad++;
      $display("FAIL unmapped_rd: got %b want 1", e);
    end
    apb_read(12'h000, d, e);
    total++;
    if (d !== 32'h0 || e !== 0) begin
      bad++;
      $display("FAIL ctrl_rd: got %h/%b want 0/0", d, e);
    end
  endtask

  task automatic do_step(input logic [31:0] ctrl);
    logic [31:0] d, wd;
    logic e, rwe, pwe;
    logic [4:0] ra;
    apb_write(12'h000, ctrl, e, rwe, ra, pwe, wd);
    total++;
    if (dbg_step_req !== 1 || dbg_resume_req !== 0 ||
        dbg_halt_req !== 0) begin
      bad++;
      $display("FAIL step_pulse: st=%b rs=%b hr=%b want 1/0/0",
               dbg_step_req, dbg_resume_req, dbg_halt_req);
    end
    cyc(1);
    total++;
    if (dbg_step_req !== 0) begin
      bad++;
      $display("FAIL step_width: got %b want 0", dbg_step_req);
    end
    core_halted = 0;
    cyc(1);
    total++;
    if (dbg_halt_req !== 1) begin
      bad++;
      $display("FAIL step_rise_hr: got %b want 1", dbg_halt_req);
    end
    core_halted = 1;
    cyc(1);
    m_cause = 4'd3;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL step_status: got %h want %h",
               d, m_status());
    end
  endtask

  task automatic do_resume();
    logic [31:0] d, wd;
    logic e, rwe, pwe;
    logic [4:0] ra;
    core_fetch_valid = 0;
    apb_write(12'h000, 32'h2, e, rwe, ra, pwe, wd);
    total++;
    if (dbg_resume_req !== 1 || dbg_step_req !== 0) begin
      bad++;
      $display("FAIL resume_pulse: rs=%b st=%b want 1/0",
               dbg_resume_req, dbg_step_req);
    end
    cyc(1);
    total++;
    if (dbg_resume_req !== 0) begin
      bad++;
      $display("FAIL resume_width: got %b want 0",
               dbg_resume_req);
    end
    core_halted = 0;
    cyc(2);
    m_run = 1; m_halted = 0; m_cause = 4'd0;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL resume_status: got %h want %h",
               d, m_status());
    end
  endtask

  task automatic test_step_resume();
    do_step(32'h4);
    do_resume();
  endtask

  task automatic test_gpr_run();
    logic [31:0] d, wd;
    logic e, rwe, pwe;
    logic [4:0] ra;
    apb_write(12'h024, 32'hDEAD_BEEF, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 1 || rwe !== 0) begin
      bad++;
      $display("FAIL gpr_run_wr: err=%b we=%b want 1/0", e, rwe);
    end
    apb_write(12'h008, $urandom, e, rwe, ra, pwe, wd);
    total++;
    if (e !== 1 || pwe !== 0) begin
      bad++;
      $display("FAIL pc_run_wr: err=%b we=%b want 1/0", e, pwe);
    end
    apb_read(12'h03C, d, e);
    total++;
    if (d !== 32'hA5A5_000B || e !== 0) begin
      bad++;
      $display("FAIL gpr_run_rd: got %h/%b want a5a5000b/0",
               d, e);
    end
  endtask

  task automatic test_breakpoint();
    logic [31:0] d, wd, a1, pc;
    logic e, rwe, pwe, fv, exp_hit;
    logic [4:0] ra;
    int sel;
    a1 = $urandom;
    apb_write(12'h100, 32'h40 | 32'($urandom_range(0, 3)),
              e, rwe, ra, pwe, wd);
    apb_write(12'h104, 32'h1, e, rwe, ra, pwe, wd);
    apb_write(12'h108, a1, e, rwe, ra, pwe, wd);
    m_bp_addr[0] = 32'h40;
    m_bp_en[0]   = 1;
    m_bp_addr[1] = a1 & ~32'h3;
    m_bp_en[1]   = 1'($urandom_range(0, 1));
    apb_write(12'h10C, {31'b0, m_bp_en[1]}, e, rwe, ra, pwe, wd);
    apb_read(12'h108, d, e);
    total++;
    if (d !== m_bp_addr[1]) begin
      bad++;
      $display("FAIL bp1_addr_rd: got %h want %h",
               d, m_bp_addr[1]);
    end
    apb_read(12'h10C, d, e);
    total++;
    if (d !== {31'b0, m_bp_en[1]}) begin
      bad++;
      $display("FAIL bp1_ctrl_rd: got %h want %0d",
               d, m_bp_en[1]);
    end
    exp_hit = 0;
    for (int i = 0; i < 30 && !exp_hit; i++) begin
      @(posedge clk); #1;
      sel = $urandom_range(0, 3);
      fv  = 1'($urandom_range(0, 1));
      pc  = $urandom;
      if (sel < 2) pc = m_bp_addr[sel] | (pc & 32'h3);
      if (i == 29) begin
        pc = 32'h40; fv = 1;
      end
      core_pc = pc;
      core_fetch_valid = fv;
      exp_hit = m_hit(pc, fv);
      #1;
      total++;
      if (dbg_bp_hit !== exp_hit) begin
        bad++;
        $display("FAIL bp_hit: pc=%h fv=%b got %b want %b",
                 pc, fv, dbg_bp_hit, exp_hit);
      end
    end
    cyc(1);
    core_fetch_valid = 0;
    m_run = 0;
    total++;
    if (dbg_halt_req !== 1) begin
      bad++;
      $display("FAIL bp_halt_req: got %b want 1", dbg_halt_req);
    end
    core_halted = 1;
    cyc(2);
    m_halted = 1; m_cause = 4'd2;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL bp_status: got %h want %h", d, m_status());
    end
    core_pc = 32'h40; core_fetch_valid = 1;
    #1;
    total++;
    if (dbg_bp_hit !== 0) begin
      bad++;
      $display("FAIL bp_hit_halted: got %b want 0", dbg_bp_hit);
    end
    core_fetch_valid = 0;
    do_resume();
  endtask

  task automatic test_ebreak_priority();
    logic [31:0] d;
    logic e;
    @(posedge clk); #1;
    core_pc = 32'h40; core_fetch_valid = 1; core_ebreak = 1;
    #1;
    total++;
    if (dbg_bp_hit !== 1) begin
      bad++;
      $display("FAIL eb_bp_hit: got %b want 1", dbg_bp_hit);
    end
    cyc(1);
    core_fetch_valid = 0; core_ebreak = 0;
    m_run = 0;
    core_halted = 1;
    cyc(2);
    m_halted = 1; m_cause = 4'd4;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL eb_status: got %h want %h", d, m_status());
    end
    do_step(32'h6);
  endtask

  task automatic test_reset_mid_step();
    logic [31:0] d, wd;
    logic e, rwe, pwe;
    logic [4:0] ra;
    apb_write(12'h000, 32'h4, e, rwe, ra, pwe, wd);
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({dbg_step_req, dbg_halt_req, dbg_resume_req}
        !== 3'b0 || prdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_async: st=%b hr=%b pr=%h want 0",
               dbg_step_req, dbg_halt_req, prdata);
    end
    core_halted = 0;
    m_run = 1; m_halted = 0; m_cause = 4'd0;
    m_bp_en[0] = 0; m_bp_en[1] = 0;
    m_bp_addr[0] = 0; m_bp_addr[1] = 0;
    @(negedge clk) rst_n = 1;
    apb_read(12'h004, d, e);
    total++;
    if (d !== m_status()) begin
      bad++;
      $display("FAIL rst_status: got %h want %h", d, m_status());
    end
    apb_read(12'h100, d, e);
    total++;
    if (d !== m_bp_addr[0]) begin
      bad++;
      $display("FAIL rst_bp0: got %h want 0", d);
    end
    core_pc = 32'h40; core_fetch_valid = 1;
    #1;
    total++;
    if (dbg_bp_hit !== m_hit(32'h40, 1'b1)) begin
      bad++;
      $display("FAIL rst_bp_hit: got %b want 0", dbg_bp_hit);
    end
    core_fetch_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0;
    core_halted = 0; core_pc = 0; core_instr = 0;
    core_fetch_valid = 0; core_ebreak = 0;
    m_run = 1; m_halted = 0; m_cause = 0;
    m_bp_addr[0] = 0; m_bp_addr[1] = 0;
    m_bp_en[0] = 0; m_bp_en[1] = 0;
    test_reset();
    test_halt_request();
    test_gpr_halted();
    test_step_resume();
    test_gpr_run();
    test_breakpoint();
    test_ebreak_priority();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
